// File: rtl/vrf_wb_issue_queue.sv
// Writeback issue queue: buffers results from two vector FUs in order and drives two VRF
// write ports. The VRF can reject either write in the same cycle, and rejected writes are retried.
module vrf_wb_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in0_vld,
    output logic                       in0_rdy,
    input  logic [ADDR_W-1:0]          in0_addr,
    input  logic [DATA_W-1:0]          in0_data,
    input  logic                       in1_vld,
    output logic                       in1_rdy,
    input  logic [ADDR_W-1:0]          in1_addr,
    input  logic [DATA_W-1:0]          in1_data,
    output logic                       wr0_vld,
    output logic [ADDR_W-1:0]          waddr0,
    output logic [DATA_W-1:0]          wdata0,
    input  logic                       wr0_conflict,
    output logic                       wr1_vld,
    output logic [ADDR_W-1:0]          waddr1,
    output logic [DATA_W-1:0]          wdata1,
    input  logic                       wr1_conflict,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  done;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head1;
    logic [PTR_W-1:0]  tail1;
    logic [PTR_W-1:0]  slot1;
    logic [CNT_W-1:0]  free;
    logic [CNT_W-1:0]  enq_cnt;
    logic [CNT_W-1:0]  pop_cnt;
    logic              has1;
    logic              has2;
    logic              enq0;
    logic              enq1;
    logic              wr1_ok;
    logic              ok0;
    logic              ok1;

    // Ready ignores same-cycle pops, so occupancy can never exceed DEPTH.
    always_comb begin
        free    = CNT_W'(DEPTH) - count;
        has1    = (count >= CNT_W'(1));
        has2    = (count >= CNT_W'(2));
        in0_rdy = rstn & (free >= CNT_W'(1));
        in1_rdy = rstn & (free >= CNT_W'(2));
        head1   = head + PTR_W'(1);
        tail1   = tail + PTR_W'(1);

        wr0_vld = rstn & has1 & ~done[head];
        waddr0  = addr_mem[head];
        wdata0  = data_mem[head];
        // Same destination as the head must not overtake it (write-after-write order).
        wr1_vld = rstn & has2 & ~done[head1] & (addr_mem[head1] != addr_mem[head]);
        waddr1  = addr_mem[head1];
        wdata1  = data_mem[head1];

        ok0     = wr0_vld & ~wr0_conflict;
        wr1_ok  = wr1_vld & ~wr1_conflict;
        ok1     = wr1_ok | (has2 & done[head1]);
        if (!ok0)
            pop_cnt = CNT_W'(0);
        else if (ok1)
            pop_cnt = CNT_W'(2);
        else
            pop_cnt = CNT_W'(1);

        enq0    = in0_vld & in0_rdy;
        enq1    = in1_vld & in1_rdy;
        enq_cnt = CNT_W'(enq0) + CNT_W'(enq1);
        slot1   = enq0 ? tail1 : tail;

        empty   = (count == CNT_W'(0));
        full    = (count == CNT_W'(DEPTH));
    end

    // A head+1 entry that wrote while the head is stalled is marked done so it is never rewritten.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else begin
            if (enq0)
                done[tail] <= 1'b0;
            if (enq1)
                done[slot1] <= 1'b0;
            if (wr1_ok)
                done[head1] <= 1'b1;
            head  <= head + PTR_W'(pop_cnt);
            tail  <= tail + PTR_W'(enq_cnt);
            count <= count + enq_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (enq0) begin
            addr_mem[tail] <= in0_addr;
            data_mem[tail] <= in0_data;
        end
        if (enq1) begin
            addr_mem[slot1] <= in1_addr;
            data_mem[slot1] <= in1_data;
        end
    end

endmodule

// File: tb/tb_vrf_wb_issue_queue.sv
// Directed bench for vrf_wb_issue_queue: inputs change and outputs are checked at the
// falling edge, with expected values written out by hand for each step.
module tb_vrf_wb_issue_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rstn;
    logic              in0_vld;
    logic              in0_rdy;
    logic [ADDR_W-1:0] in0_addr;
    logic [DATA_W-1:0] in0_data;
    logic              in1_vld;
    logic              in1_rdy;
    logic [ADDR_W-1:0] in1_addr;
    logic [DATA_W-1:0] in1_data;
    logic              wr0_vld;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              wr0_conflict;
    logic              wr1_vld;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic              wr1_conflict;
    logic [3:0]        count;
    logic              empty;
    logic              full;

    int total;
    int bad;
    int w7_writes;
    int a2_retries;
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] exp_d;

    vrf_wb_issue_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn),
        .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_addr(in0_addr), .in0_data(in0_data),
        .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_addr(in1_addr), .in1_data(in1_data),
        .wr0_vld(wr0_vld), .waddr0(waddr0), .wdata0(wdata0), .wr0_conflict(wr0_conflict),
        .wr1_vld(wr1_vld), .waddr1(waddr1), .wdata1(wdata1), .wr1_conflict(wr1_conflict),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts real writes to vreg 7 and rejected attempts at vreg 2 (only the retry test uses them).
    always @(posedge clk) begin
        if (rstn) begin
            if (wr1_vld && !wr1_conflict && waddr1 == 5'd7)
                w7_writes++;
            if (wr0_vld && wr0_conflict && waddr0 == 5'd2)
                a2_retries++;
        end
    end

    task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                 input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                                 input logic c0, input logic c1);
        in0_vld      = v0;
        in0_addr     = a0;
        in0_data     = d0;
        in1_vld      = v1;
        in1_addr     = a1;
        in1_data     = d1;
        wr0_conflict = c0;
        wr1_conflict = c1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        w7_writes = 0;
        a2_retries = 0;
        rstn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset: outputs forced low while rstn is low
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_wr0_vld", 64'(wr0_vld), 64'd0);
        checkOutput("rst_wr1_vld", 64'(wr1_vld), 64'd0);
        checkOutput("rst_in0_rdy", 64'(in0_rdy), 64'd0);
        checkOutput("rst_in1_rdy", 64'(in1_rdy), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("post_count", 64'(count), 64'd0);
        checkOutput("post_empty", 64'(empty), 64'd1);
        checkOutput("post_full", 64'(full), 64'd0);
        checkOutput("post_in0_rdy", 64'(in0_rdy), 64'd1);
        checkOutput("post_in1_rdy", 64'(in1_rdy), 64'd1);

        // Single enqueue, no same-cycle bypass
        applyStimulus(1, 5'd5, 32'hA5A5_0001, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t1_no_bypass", 64'(wr0_vld), 64'd0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t1_wr0_vld", 64'(wr0_vld), 64'd1);
        checkOutput("t1_waddr0", 64'(waddr0), 64'd5);
        checkOutput("t1_wdata0", 64'(wdata0), 64'hA5A5_0001);
        checkOutput("t1_wr1_vld", 64'(wr1_vld), 64'd0);
        checkOutput("t1_count", 64'(count), 64'd1);
        @(negedge clk);
        #1;
        checkOutput("t1_empty", 64'(empty), 64'd1);

        // Dual enqueue, dual issue
        applyStimulus(1, 5'd3, 32'h0000_0033, 1, 5'd9, 32'h0000_0099, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t2_count", 64'(count), 64'd2);
        checkOutput("t2_wr0_vld", 64'(wr0_vld), 64'd1);
        checkOutput("t2_waddr0", 64'(waddr0), 64'd3);
        checkOutput("t2_wdata0", 64'(wdata0), 64'h33);
        checkOutput("t2_wr1_vld", 64'(wr1_vld), 64'd1);
        checkOutput("t2_waddr1", 64'(waddr1), 64'd9);
        checkOutput("t2_wdata1", 64'(wdata1), 64'h99);
        @(negedge clk);
        #1;
        checkOutput("t2_count_after", 64'(count), 64'd0);

        // Same destination twice: second must wait behind the first
        applyStimulus(1, 5'd4, 32'h0000_0041, 1, 5'd4, 32'h0000_0042, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t3_count_a", 64'(count), 64'd2);
        checkOutput("t3_wr0_vld_a", 64'(wr0_vld), 64'd1);
        checkOutput("t3_wdata0_a", 64'(wdata0), 64'h41);
        checkOutput("t3_wr1_blocked", 64'(wr1_vld), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("t3_count_b", 64'(count), 64'd1);
        checkOutput("t3_wr0_vld_b", 64'(wr0_vld), 64'd1);
        checkOutput("t3_waddr0_b", 64'(waddr0), 64'd4);
        checkOutput("t3_wdata0_b", 64'(wdata0), 64'h42);
        checkOutput("t3_wr1_vld_b", 64'(wr1_vld), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("t3_count_c", 64'(count), 64'd0);

        // Head stalled 3 cycles, head+1 writes once, then both pop together
        applyStimulus(1, 5'd2, 32'h0000_0020, 1, 5'd7, 32'h0000_0070, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        checkOutput("t4_wr1_vld_0", 64'(wr1_vld), 64'd1);
        checkOutput("t4_waddr1", 64'(waddr1), 64'd7);
        @(negedge clk);
        #1;
        checkOutput("t4_wr1_vld_1", 64'(wr1_vld), 64'd0);
        checkOutput("t4_wr0_retry", 64'(wr0_vld), 64'd1);
        checkOutput("t4_count_hold", 64'(count), 64'd2);
        @(negedge clk);
        #1;
        checkOutput("t4_wr1_vld_2", 64'(wr1_vld), 64'd0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t4_wr1_vld_3", 64'(wr1_vld), 64'd0);
        checkOutput("t4_waddr0", 64'(waddr0), 64'd2);
        checkOutput("t4_wdata0", 64'(wdata0), 64'h20);
        @(negedge clk);
        #1;
        checkOutput("t4_count_after", 64'(count), 64'd0);
        checkOutput("t4_w7_writes", 64'(w7_writes), 64'd1);
        checkOutput("t4_a2_retries", 64'(a2_retries), 64'd3);

        // Fill to full with both ports rejected, then drain two per cycle
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 5'(10 + 2 * k), 32'(32'h500 + 2 * k),
                          1, 5'(11 + 2 * k), 32'(32'h501 + 2 * k), 1, 1);
            sb.push_back(32'(32'h500 + 2 * k));
            sb.push_back(32'(32'h501 + 2 * k));
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        checkOutput("t5_count", 64'(count), 64'd8);
        checkOutput("t5_full", 64'(full), 64'd1);
        checkOutput("t5_in0_rdy", 64'(in0_rdy), 64'd0);
        checkOutput("t5_in1_rdy", 64'(in1_rdy), 64'd0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t5_hold_count", 64'(count), 64'd8);
        for (int j = 0; j < 4; j++) begin
            checkOutput("t5_drain_count", 64'(count), 64'(8 - 2 * j));
            checkOutput("t5_drain_wr1_vld", 64'(wr1_vld), 64'd1);
            exp_d = sb.pop_front();
            checkOutput("t5_drain_wdata0", 64'(wdata0), 64'(exp_d));
            exp_d = sb.pop_front();
            checkOutput("t5_drain_wdata1", 64'(wdata1), 64'(exp_d));
            @(negedge clk);
            #1;
        end
        checkOutput("t5_empty", 64'(empty), 64'd1);

        // Reset with 5 entries queued discards them all
        applyStimulus(1, 5'd20, 32'hDEAD_0000, 1, 5'd21, 32'hDEAD_0001, 1, 1);
        @(negedge clk);
        applyStimulus(1, 5'd22, 32'hDEAD_0002, 1, 5'd23, 32'hDEAD_0003, 1, 1);
        @(negedge clk);
        applyStimulus(1, 5'd24, 32'hDEAD_0004, 0, 0, 0, 1, 1);
        @(negedge clk);
        #1;
        checkOutput("t6_count_pre", 64'(count), 64'd5);
        rstn = 1'b0;
        applyStimulus(1, 5'd25, 32'hDEAD_0005, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t6_rst_wr0_vld", 64'(wr0_vld), 64'd0);
        checkOutput("t6_rst_wr1_vld", 64'(wr1_vld), 64'd0);
        checkOutput("t6_rst_in0_rdy", 64'(in0_rdy), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t6_count", 64'(count), 64'd0);
        checkOutput("t6_empty", 64'(empty), 64'd1);
        checkOutput("t6_wr0_vld", 64'(wr0_vld), 64'd0);
        checkOutput("t6_wr1_vld", 64'(wr1_vld), 64'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            #1;
            checkOutput("t6_no_stale", 64'(wr0_vld), 64'd0);
        end
        applyStimulus(1, 5'd6, 32'h0000_0066, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t6_new_wr0_vld", 64'(wr0_vld), 64'd1);
        checkOutput("t6_new_waddr0", 64'(waddr0), 64'd6);
        checkOutput("t6_new_wdata0", 64'(wdata0), 64'h66);
        checkOutput("t6_new_count", 64'(count), 64'd1);
        @(negedge clk);
        #1;
        checkOutput("t6_final_empty", 64'(empty), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
